// File: rtl/traffic_pkg.sv
// Shared traffic-light controller package: FSM state encoding for the tick
// monitor, the nominal divider period, and the tick counter width.
// Optional build macro used by tick_monitor: TICK_MONITOR_STATS_EN.
package traffic_pkg;

  // Nominal clk cycles per OneHz tick; the divider uses the same constant.
  localparam int DEFAULT_CLK_HZ = 100000;

  // Width of the free-running rising-edge counter.
  localparam int TICK_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } tm_state_t;

endpackage

// File: rtl/tick_monitor_if.sv
// Bundle of the tick monitor's tick input, error clear and status outputs.
// The master side drives OneHz/Clear_Err; the slave (the monitor) answers.
// There is no valid/ready handshake here: Period_Valid is a one-cycle strobe
// that marks the cycle in which Period holds a new measurement, and the
// receiver must capture it in that cycle (there is no back-pressure).
// With TICK_MONITOR_STATS_EN defined, Min_Period/Max_Period are added.
interface tick_monitor_if #(
  parameter int CNT_W = 20
);
  import traffic_pkg::*;

  logic                  OneHz;
  logic                  Clear_Err;
  logic [CNT_W-1:0]      Period;
  logic                  Period_Valid;
  logic                  Early_Err;
  logic                  Late_Err;
  logic                  Locked;
  logic [TICK_CNT_W-1:0] Tick_Count;
`ifdef TICK_MONITOR_STATS_EN
  logic [CNT_W-1:0]      Min_Period;
  logic [CNT_W-1:0]      Max_Period;

  modport master (
    output OneHz, Clear_Err,
    input  Period, Period_Valid, Early_Err, Late_Err, Locked, Tick_Count,
    input  Min_Period, Max_Period
  );

  modport slave (
    input  OneHz, Clear_Err,
    output Period, Period_Valid, Early_Err, Late_Err, Locked, Tick_Count,
    output Min_Period, Max_Period
  );
`else
  modport master (
    output OneHz, Clear_Err,
    input  Period, Period_Valid, Early_Err, Late_Err, Locked, Tick_Count
  );

  modport slave (
    input  OneHz, Clear_Err,
    output Period, Period_Valid, Early_Err, Late_Err, Locked, Tick_Count
  );
`endif

endinterface

// File: rtl/edge_detect_rise.sv
// Rising-edge detector: one register plus an AND. The output is high for
// the single cycle in which i_sig is 1 and was 0 on the previous cycle.
// Because the register resets to 0, a high input right after reset counts
// as an edge.
module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_q;

  // Delay the input by one cycle for comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sig_q <= 1'b0;
    else        r_sig_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/tick_monitor.sv
// Tick monitor: measures the interval between OneHz rising edges in clk
// cycles, flags early/late ticks (sticky), and asserts Locked after
// LOCK_COUNT consecutive in-window intervals.
// Optional build macro: TICK_MONITOR_STATS_EN adds Min_Period/Max_Period.
// o_dbg_state exposes the FSM state for observation.
module tick_monitor
  import traffic_pkg::*;
#(
  parameter int CLK_HZ     = DEFAULT_CLK_HZ,
  parameter int TOL        = 10,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 20
) (
  input  logic           clk,
  input  logic           Async_Reset_n,
  tick_monitor_if.slave  bus,
  output tm_state_t      o_dbg_state
);

  localparam logic [CNT_W-1:0] C_LO   = CNT_W'(CLK_HZ - TOL);
  localparam logic [CNT_W-1:0] C_HI   = CNT_W'(CLK_HZ + TOL);
  localparam logic [CNT_W-1:0] C_SAT  = CNT_W'(CLK_HZ + TOL + 1);
  localparam logic [3:0]       C_LOCK = 4'(LOCK_COUNT);

  logic                  w_edge;
  logic                  w_meas_edge;
  logic                  w_early;
  logic                  w_late;
  logic [3:0]            w_good_inc;
  tm_state_t             w_state_nxt;

  tm_state_t             r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_period;
  logic                  r_period_valid;
  logic                  r_early_err;
  logic                  r_late_err;
  logic                  r_locked;
  logic [3:0]            r_good;
  logic [TICK_CNT_W-1:0] r_tick_count;

  edge_detect_rise u_edge (
    .clk    (clk),
    .rst_n  (Async_Reset_n),
    .i_sig  (bus.OneHz),
    .o_rise (w_edge)
  );

  // Next state and per-cycle decisions: measured edge, early interval, timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_meas_edge = 1'b0;
    w_early     = 1'b0;
    w_late      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge) w_state_nxt = MEASURE;
      end
      MEASURE: begin
        if (w_edge) begin
          w_meas_edge = 1'b1;
          w_early     = (r_cnt < C_LO);
        end else if (r_cnt == C_HI) begin
          w_late      = 1'b1;
          w_state_nxt = LOST;
        end
      end
      LOST: begin
        // The interval ending on this edge started in timeout, so it is dropped.
        if (w_edge) w_state_nxt = MEASURE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Good-interval run length, saturating at the lock threshold.
  assign w_good_inc = (r_good >= C_LOCK) ? C_LOCK : r_good + 4'd1;

  // State register.
  always_ff @(posedge clk or negedge Async_Reset_n) begin
    if (!Async_Reset_n) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  // Interval counter: restarts at 1 on an edge, otherwise counts up and holds saturated.
  always_ff @(posedge clk or negedge Async_Reset_n) begin
    if (!Async_Reset_n)      r_cnt <= '0;
    else if (w_edge)         r_cnt <= CNT_W'(1);
    else if (r_cnt != C_SAT) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Capture the measured interval and strobe its valid for one cycle.
  always_ff @(posedge clk or negedge Async_Reset_n) begin
    if (!Async_Reset_n) begin
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_period_valid <= w_meas_edge;
      if (w_meas_edge) r_period <= r_cnt;
    end
  end

  // Lock tracking: any early or late interval breaks the run of good intervals.
  always_ff @(posedge clk or negedge Async_Reset_n) begin
    if (!Async_Reset_n) begin
      r_good   <= '0;
      r_locked <= 1'b0;
    end else if (w_late || (w_meas_edge && w_early)) begin
      r_good   <= '0;
      r_locked <= 1'b0;
    end else if (w_meas_edge) begin
      r_good <= w_good_inc;
      if (w_good_inc == C_LOCK) r_locked <= 1'b1;
    end
  end

  // Sticky error flags; a new error in the same cycle as Clear_Err wins.
  always_ff @(posedge clk or negedge Async_Reset_n) begin
    if (!Async_Reset_n) begin
      r_early_err <= 1'b0;
      r_late_err  <= 1'b0;
    end else begin
      if (w_meas_edge && w_early) r_early_err <= 1'b1;
      else if (bus.Clear_Err)     r_early_err <= 1'b0;
      if (w_late)                 r_late_err  <= 1'b1;
      else if (bus.Clear_Err)     r_late_err  <= 1'b0;
    end
  end

  // Count every rising edge, wrapping silently.
  always_ff @(posedge clk or negedge Async_Reset_n) begin
    if (!Async_Reset_n) r_tick_count <= '0;
    else if (w_edge)    r_tick_count <= r_tick_count + TICK_CNT_W'(1);
  end

`ifdef TICK_MONITOR_STATS_EN
  logic [CNT_W-1:0] r_min_period;
  logic [CNT_W-1:0] r_max_period;

  // Running min/max of measured periods; a clear coincident with a sample restarts from it.
  always_ff @(posedge clk or negedge Async_Reset_n) begin
    if (!Async_Reset_n) begin
      r_min_period <= '1;
      r_max_period <= '0;
    end else if (bus.Clear_Err) begin
      r_min_period <= w_meas_edge ? r_cnt : '1;
      r_max_period <= w_meas_edge ? r_cnt : '0;
    end else if (w_meas_edge) begin
      if (r_cnt < r_min_period) r_min_period <= r_cnt;
      if (r_cnt > r_max_period) r_max_period <= r_cnt;
    end
  end

  assign bus.Min_Period = r_min_period;
  assign bus.Max_Period = r_max_period;
`endif

  assign bus.Period       = r_period;
  assign bus.Period_Valid = r_period_valid;
  assign bus.Early_Err    = r_early_err;
  assign bus.Late_Err     = r_late_err;
  assign bus.Locked       = r_locked;
  assign bus.Tick_Count   = r_tick_count;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_tick_monitor.sv
// Bench for tick_monitor with CLK_HZ=100, TOL=2, LOCK_COUNT=3.
// Directed vector table, hand-written timeout and async-reset sequences,
// then randomized intervals checked against an interval-level model.
// Min/Max checks are compiled only with TICK_MONITOR_STATS_EN.
module tb_tick_monitor;
  import traffic_pkg::*;

  localparam int CLK_HZ = 100;
  localparam int TOL    = 2;
  localparam int LOCK_C = 3;
  localparam int CNT_W  = 20;

  logic      clk;
  logic      rst_n;
  tm_state_t dbg_state;

  tick_monitor_if #(.CNT_W(CNT_W)) bus ();

  tick_monitor #(
    .CLK_HZ     (CLK_HZ),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK_C),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .Async_Reset_n (rst_n),
    .bus           (bus),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] exp_q[$];
  bit sb_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every Period_Valid in the random phase must match the next queued period.
  always @(negedge clk) begin
    if (sb_en && bus.Period_Valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: unexpected Period_Valid with Period=%0d", bus.Period);
      end else begin
        logic [CNT_W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_period", bus.Period, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at the negedge right after an edge pulse; drives the next pulse n
  // cycles after the previous one, optionally pulsing Clear_Err on the second
  // cycle of the gap, and returns at the negedge following the new edge.
  task automatic run_interval(input int n, input bit clr);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      if (i == 1) chk("pv_low", bus.Period_Valid, 0);
      bus.Clear_Err = clr && (i == 1);
    end
    bus.OneHz = 1'b1;
    @(negedge clk);
    bus.OneHz     = 1'b0;
    bus.Clear_Err = 1'b0;
  endtask

  task automatic first_edge();
    bus.OneHz = 1'b1;
    @(negedge clk);
    bus.OneHz = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.OneHz = 1'b0;
    bus.Clear_Err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_edge(input string tag, input int period, input bit valid,
                            input bit early, input bit late, input bit locked,
                            input int tick);
    chk({tag, ".period"}, bus.Period, period);
    chk({tag, ".valid"},  bus.Period_Valid, valid);
    chk({tag, ".early"},  bus.Early_Err, early);
    chk({tag, ".late"},   bus.Late_Err, late);
    chk({tag, ".locked"}, bus.Locked, locked);
    chk({tag, ".tick"},   bus.Tick_Count, tick);
  endtask

  // ---------------- reference model (interval level) ----------------
  bit m_started, m_early, m_late, m_locked;
  int m_good, m_period, m_tick;
  bit m_valid;

  function automatic void model_init();
    m_started = 0; m_early = 0; m_late = 0; m_locked = 0;
    m_good = 0; m_period = 0; m_tick = 0; m_valid = 0;
  endfunction

  // One edge arriving n cycles after the previous one; clr pulsed during the gap.
  function automatic void model_edge(input int n, input bit clr);
    if (clr) begin
      m_early = 0;
      m_late  = 0;
    end
    m_tick  = (m_tick + 1) % 256;
    m_valid = 0;
    if (!m_started) begin
      m_started = 1;
    end else if (n > CLK_HZ + TOL) begin
      // Timed out during the gap; this edge only re-arms measurement.
      m_late = 1; m_locked = 0; m_good = 0;
    end else begin
      m_valid  = 1;
      m_period = n;
      exp_q.push_back(CNT_W'(n));
      if (n < CLK_HZ - TOL) begin
        m_early = 1; m_good = 0; m_locked = 0;
      end else begin
        m_good = (m_good + 1 > LOCK_C) ? LOCK_C : m_good + 1;
        if (m_good == LOCK_C) m_locked = 1;
      end
    end
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    int gap;     // 0 = first edge after reset
    bit clr;
    int period;
    bit valid;
    bit early;
    bit late;
    bit locked;
    int tick;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{0,   0, 0,   0, 0, 0, 0, 1};
    vecs[1]  = '{100, 0, 100, 1, 0, 0, 0, 2};
    vecs[2]  = '{100, 0, 100, 1, 0, 0, 0, 3};
    vecs[3]  = '{100, 0, 100, 1, 0, 0, 1, 4};
    vecs[4]  = '{97,  0, 97,  1, 1, 0, 0, 5};
    vecs[5]  = '{100, 0, 100, 1, 1, 0, 0, 6};
    vecs[6]  = '{100, 0, 100, 1, 1, 0, 0, 7};
    vecs[7]  = '{100, 0, 100, 1, 1, 0, 1, 8};
    vecs[8]  = '{100, 1, 100, 1, 0, 0, 1, 9};
    vecs[9]  = '{98,  0, 98,  1, 0, 0, 1, 10};
    vecs[10] = '{102, 0, 102, 1, 0, 0, 1, 11};
    vecs[11] = '{2,   1, 2,   1, 1, 0, 0, 12};
    vecs[12] = '{102, 0, 102, 1, 1, 0, 0, 13};
    vecs[13] = '{98,  0, 98,  1, 1, 0, 0, 14};
    vecs[14] = '{100, 0, 100, 1, 1, 0, 1, 15};
    vecs[15] = '{100, 1, 100, 1, 0, 0, 1, 16};
    vecs[16] = '{97,  0, 97,  1, 1, 0, 0, 17};
    vecs[17] = '{100, 0, 100, 1, 1, 0, 0, 18};
    vecs[18] = '{100, 0, 100, 1, 1, 0, 0, 19};
    vecs[19] = '{100, 0, 100, 1, 1, 0, 1, 20};

    rst_n = 1'b0;
    bus.OneHz = 1'b0;
    bus.Clear_Err = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check_edge("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.state", dbg_state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: lock-up, early error, clear, boundaries, clear-vs-error.
    for (int v = 0; v < 20; v++) begin
      if (vecs[v].gap == 0) first_edge();
      else run_interval(vecs[v].gap, vecs[v].clr);
      check_edge($sformatf("vec%0d", v), vecs[v].period, vecs[v].valid,
                 vecs[v].early, vecs[v].late, vecs[v].locked, vecs[v].tick);
    end
    chk("vec.state", dbg_state, MEASURE);

    // Timeout: edges stop while locked.
    for (int k = 2; k <= 150; k++) begin
      @(negedge clk);
      if (k == 102) begin
        chk("late.before", bus.Late_Err, 0);
        chk("late.locked_before", bus.Locked, 1);
      end
      if (k == 103) begin
        chk("late.set", bus.Late_Err, 1);
        chk("late.locked_drop", bus.Locked, 0);
        chk("late.state", dbg_state, LOST);
      end
    end
    first_edge();
    check_edge("lost_exit", 100, 0, 1, 1, 0, 21);
    chk("lost_exit.state", dbg_state, MEASURE);
    run_interval(100, 0);
    check_edge("after_lost", 100, 1, 1, 1, 0, 22);

    // Async reset in the middle of an interval.
    repeat (49) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_edge("areset", 0, 0, 0, 0, 0, 0);
    chk("areset.state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    first_edge();
    check_edge("areset_first", 0, 0, 0, 0, 0, 1);
    chk("areset_first.state", dbg_state, MEASURE);
    run_interval(100, 0);
    check_edge("areset_second", 100, 1, 0, 0, 0, 2);

`ifdef TICK_MONITOR_STATS_EN
    run_interval(99, 1);
    run_interval(101, 0);
    run_interval(100, 0);
    chk("stats.min", bus.Min_Period, 99);
    chk("stats.max", bus.Max_Period, 101);
`endif

    // Randomized intervals against the model.
    do_reset();
    model_init();
    sb_en = 1'b1;
    first_edge();
    model_edge(0, 0);
    check_edge("rnd_first", m_period, m_valid, m_early, m_late, m_locked, m_tick);
    for (int r = 0; r < 40; r++) begin
      int sel, n;
      bit clr;
      sel = $urandom_range(0, 9);
      if (sel < 6)       n = $urandom_range(96, 104);
      else if (sel == 6) n = $urandom_range(2, 20);
      else if (sel == 7) n = $urandom_range(103, 130);
      else               n = (sel == 8) ? 98 : 102;
      clr = ($urandom_range(0, 4) == 0);
      model_edge(n, clr);
      run_interval(n, clr);
      check_edge($sformatf("rnd%0d_n%0d", r, n), m_period, m_valid, m_early,
                 m_late, m_locked, m_tick);
    end
    @(negedge clk);
    sb_en = 1'b0;
    chk("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_monitor.md
Name: tick_monitor

Overview:
- Receiving end of the clock-divider tick: consumes the divider's OneHz output and measures each tick interval in clk cycles.
- Flags intervals that fall outside a tolerance window around the nominal period.
- Raises a lock indication once the tick is stable.
- Sits beside the divider in the traffic-light controller; the sequencer gates phase timing on Locked, and the fault path uses Early_Err/Late_Err.

Parameters:
CLK_HZ, 100000, nominal clk cycles between tick rising edges (100 kHz system clock)
TOL, 10, allowed deviation in cycles, either side of CLK_HZ
LOCK_COUNT, 3, consecutive in-window intervals required to assert Locked (1..15)
CNT_W, 20, width of interval counter and Period; must hold CLK_HZ+TOL+1

Ports:
clk  input  1  system clock, all logic on rising edge
Async_Reset_n  input  1  asynchronous active-low reset
OneHz  input  1  tick from divider, synchronous to clk, any duty cycle
Clear_Err  input  1  synchronous pulse: clears sticky errors
Period  output  CNT_W  last measured interval in cycles
Period_Valid  output  1  one-cycle strobe when Period updates
Early_Err  output  1  sticky: interval < CLK_HZ-TOL
Late_Err  output  1  sticky: no edge by CLK_HZ+TOL cycles
Locked  output  1  LOCK_COUNT consecutive good intervals seen
Tick_Count  output  8  rising edges seen, wraps 255->0

Behaviour:
- Clock and reset decided: one clock (clk); reset is asynchronous and active-low (Async_Reset_n).
- Reset values: all outputs 0, counter 0, edge register 0, state IDLE.
- Edge detect: OneHz_q <= OneHz. Edge = OneHz & ~OneHz_q.
  - A high OneHz on the first cycle after reset counts as an edge.
- Counter:
  - On an edge cycle, cnt <= 1.
  - Otherwise cnt increments, saturating at CLK_HZ+TOL+1.
  - Consequence: edges N cycles apart yield Period = N.
- States:
  - IDLE:
    - First edge -> MEASURE.
    - Tick_Count increments. No Period_Valid.
  - MEASURE, on edge:
    - Period <= cnt; Period_Valid = 1 next cycle; Tick_Count++.
    - If cnt < CLK_HZ-TOL: Early_Err <= 1, good count <= 0, Locked <= 0.
    - Otherwise good count++ (saturating at LOCK_COUNT). Locked <= 1 when good count reaches LOCK_COUNT.
    - Stay in MEASURE.
  - MEASURE, no edge and cnt == CLK_HZ+TOL:
    - Late_Err <= 1, Locked <= 0, good count <= 0 -> LOST.
  - LOST:
    - No Period update; the counter holds saturated.
    - Next edge -> MEASURE. That interval is discarded: no Period_Valid, counter restarts.
- Latency: Period/Period_Valid/error flags are registered one cycle after the edge cycle.
- Boundary rules:
  - Interval exactly CLK_HZ±TOL is good.
  - Clear_Err coincident with a new error: the error wins (flag stays 1).
  - Clear_Err never affects Locked or the good count.
  - Tick_Count wraps silently.
  - An async reset mid-interval returns to IDLE immediately.

Optional Feature:
- Macro TICK_MONITOR_STATS_EN.
- Defined:
  - Adds outputs Min_Period and Max_Period (CNT_W each).
  - Both are updated on every Period_Valid.
  - Reset values: Min = all ones, Max = 0. Clear_Err re-initialises them.
- Undefined: ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (traffic_pkg):
  - State enum (IDLE, MEASURE, LOST).
  - Default CLK_HZ constant, shared with the divider so both agree on the nominal period.
  - Tick_Count width constant.
- One natural sub-module: edge_detect_rise (register plus AND), reused by the sequencer for button inputs.

Test Plan:
All scenarios use CLK_HZ=100, TOL=2, LOCK_COUNT=3.
1. Reset released, edges every 100 cycles ×4 -> Period=100 on each valid; Locked=1 after the 4th edge (3 good intervals); no errors; Tick_Count=4.
2. Locked, then one interval of 97 -> Early_Err=1, Locked=0, Period=97; three further 100-cycle intervals -> Locked=1, Early_Err still 1; Clear_Err pulse -> Early_Err=0.
3. Edges stop after lock -> Late_Err=1 exactly 102 cycles after the last edge, Locked=0, state LOST; the next edge produces no Period_Valid; the following 100-cycle interval gives Period=100.
4. Boundary intervals 98 and 102 -> no errors, counted as good.
5. Async_Reset_n low mid-interval (cycle 50) -> all outputs 0 immediately; the next edge behaves as IDLE's first edge.
6. With TICK_MONITOR_STATS_EN, intervals 99, 101, 100 -> Min_Period=99, Max_Period=101.
